// File: rtl/alu_arbiter_if.sv
// Requester-side and ALU-side signal bundle for alu_arbiter.
// slave = arbiter view, master = requester/ALU environment view.
interface alu_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 2
);
  logic [NUM_REQ-1:0]            i_req_valid;
  logic [NUM_REQ-1:0]            o_req_ready;
  logic [4*NUM_REQ-1:0]          i_req_op;
  logic [DATA_WIDTH*NUM_REQ-1:0] i_req_data1;
  logic [DATA_WIDTH*NUM_REQ-1:0] i_req_data2;
  logic [NUM_REQ-1:0]            i_req_carry;
  logic [NUM_REQ-1:0]            o_rsp_valid;
  logic [NUM_REQ-1:0]            i_rsp_ready;
  logic [DATA_WIDTH-1:0]         o_rsp_result;
  logic                          o_rsp_zero;
  logic                          o_busy;
  logic [3:0]                    o_alu_op;
  logic [DATA_WIDTH-1:0]         o_alu_data1;
  logic [DATA_WIDTH-1:0]         o_alu_data2;
  logic                          o_alu_carry;
  logic [DATA_WIDTH-1:0]         i_alu_result;
  logic                          i_alu_zero;

  modport slave (
    input  i_req_valid, i_req_op, i_req_data1, i_req_data2, i_req_carry,
    input  i_rsp_ready, i_alu_result, i_alu_zero,
    output o_req_ready, o_rsp_valid, o_rsp_result, o_rsp_zero, o_busy,
    output o_alu_op, o_alu_data1, o_alu_data2, o_alu_carry
  );

  modport master (
    output i_req_valid, i_req_op, i_req_data1, i_req_data2, i_req_carry,
    output i_rsp_ready, i_alu_result, i_alu_zero,
    input  o_req_ready, o_rsp_valid, o_rsp_result, o_rsp_zero, o_busy,
    input  o_alu_op, o_alu_data1, o_alu_data2, o_alu_carry
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU among NUM_REQ requesters.
// Each operation walks IDLE (grant+capture) -> EXEC (ALU settles) -> RESP (hold until taken).
module alu_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 2
) (
  input  logic         i_clock,
  input  logic         i_reset,
  alu_arbiter_if.slave bus
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                r_state;
  logic [IW-1:0]         r_last;
  logic [IW-1:0]         r_gnt;
  logic [3:0]            r_op;
  logic [DATA_WIDTH-1:0] r_data1;
  logic [DATA_WIDTH-1:0] r_data2;
  logic                  r_carry;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_zero;
  logic [NUM_REQ-1:0]    r_rsp_valid;
  logic                  r_busy;

  logic                  w_found;
  logic [IW-1:0]         w_gnt;
  logic [IW-1:0]         w_idx;
  logic [NUM_REQ-1:0]    w_ready;
  logic [NUM_REQ-1:0]    w_gnt_oh;
  logic [3:0]            w_op;
  logic [DATA_WIDTH-1:0] w_data1;
  logic [DATA_WIDTH-1:0] w_data2;
  logic                  w_carry;

  // Search starts one past the last served requester, so a requester that
  // was just served has the lowest priority on its next attempt.
  always_comb begin : rr_pick
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = r_last;
    for (int n = 0; n < NUM_REQ; n++) begin
      w_idx = (w_idx == IW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
      if (!w_found && bus.i_req_valid[w_idx]) begin
        w_found = 1'b1;
        w_gnt   = w_idx;
      end
    end
  end

  always_comb begin : grant_decode
    w_ready  = '0;
    w_gnt_oh = '0;
    w_op     = '0;
    w_data1  = '0;
    w_data2  = '0;
    w_carry  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_gnt == IW'(k)) begin
        w_ready[k] = (r_state == IDLE) && w_found && !i_reset;
        w_op       = bus.i_req_op[k*4 +: 4];
        w_data1    = bus.i_req_data1[k*DATA_WIDTH +: DATA_WIDTH];
        w_data2    = bus.i_req_data2[k*DATA_WIDTH +: DATA_WIDTH];
        w_carry    = bus.i_req_carry[k];
      end
      if (r_gnt == IW'(k)) begin
        w_gnt_oh[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin : fsm
    if (i_reset) begin
      r_state     <= IDLE;
      r_last      <= IW'(NUM_REQ - 1);
      r_gnt       <= '0;
      r_op        <= '0;
      r_data1     <= '0;
      r_data2     <= '0;
      r_carry     <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_rsp_valid <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        // IDLE -> EXEC: latch the granted requester's operands
        IDLE: begin
          if (w_found) begin
            r_gnt   <= w_gnt;
            r_op    <= w_op;
            r_data1 <= w_data1;
            r_data2 <= w_data2;
            r_carry <= w_carry;
            r_busy  <= 1'b1;
            r_state <= EXEC;
          end
        end
        // EXEC -> RESP: sample the ALU after one full cycle of settling
        EXEC: begin
          r_result    <= bus.i_alu_result;
          r_zero      <= bus.i_alu_zero;
          r_rsp_valid <= w_gnt_oh;
          r_state     <= RESP;
        end
        // RESP -> IDLE: only the granted requester's ready completes the transfer
        RESP: begin
          if (bus.i_rsp_ready[r_gnt]) begin
            r_rsp_valid <= '0;
            r_busy      <= 1'b0;
            r_last      <= r_gnt;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_rsp_valid <= '0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_req_ready  = w_ready;
  assign bus.o_rsp_valid  = r_rsp_valid;
  assign bus.o_rsp_result = r_result;
  assign bus.o_rsp_zero   = r_zero;
  assign bus.o_busy       = r_busy;
  assign bus.o_alu_op     = r_op;
  assign bus.o_alu_data1  = r_data1;
  assign bus.o_alu_data2  = r_data2;
  assign bus.o_alu_carry  = r_carry;

endmodule
